// File: rtl/lbm_grid_pkg.sv
// Shared defaults, types and FSM encoding for the lattice grid read path.
`timescale 1ns/1ps
package lbm_grid_pkg;
   localparam int DEFAULT_GRID_DIM      = 16 * 16;
   localparam int DEFAULT_ADDRESS_WIDTH = $clog2(DEFAULT_GRID_DIM);
   localparam int DATA_WIDTH            = 16;
   localparam int FIFO_DEPTH            = 4;
   localparam int FIFO_CNT_W            = $clog2(FIFO_DEPTH + 1);

   typedef logic [DATA_WIDTH-1:0] cell_word_t;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} grid_rd_state_t;
endpackage

// File: rtl/grid_rd_fifo.sv
// Four-entry synchronous FIFO of {address, cell word} pairs; head is read combinationally.
`timescale 1ns/1ps
module grid_rd_fifo
   import lbm_grid_pkg::*;
#(
   parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     push,
   input  logic [ADDRESS_WIDTH-1:0] push_addr,
   input  cell_word_t               push_data,
   input  logic                     pop,
   output logic [ADDRESS_WIDTH-1:0] head_addr,
   output cell_word_t               head_data,
   output logic [FIFO_CNT_W-1:0]    count,
   output logic                     full,
   output logic                     empty
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [ADDRESS_WIDTH-1:0] addr_q [FIFO_DEPTH];
   cell_word_t               data_q [FIFO_DEPTH];
   logic [PTR_W-1:0]         wr_ptr;
   logic [PTR_W-1:0]         rd_ptr;

   assign head_addr = addr_q[rd_ptr];
   assign head_data = data_q[rd_ptr];
   assign full      = (count == FIFO_CNT_W'(FIFO_DEPTH));
   assign empty     = (count == '0);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         // NOTE: the storage drives the output ports directly and is tiny, so it is reset
         // like ordinary registers to hold Out_data/Out_addr at 0 during reset.
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // When full, a push lands in the slot the simultaneous pop is vacating.
         if (push) begin
            addr_q[wr_ptr] <= push_addr;
            data_q[wr_ptr] <= push_data;
            wr_ptr         <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + FIFO_CNT_W'(1);
            2'b01:   count <= count - FIFO_CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   no_overflow: assert property (@(posedge Clk) disable iff (!Reset) !(push && full && !pop));

endmodule

// File: rtl/grid_reader.sv
// Sweeps every lattice cell address once per Start and streams the words out over
// valid/ready, throttling reads so the 4-entry buffer can never overflow.
`timescale 1ns/1ps
module grid_reader
   import lbm_grid_pkg::*;
#(
   parameter int GRID_DIM      = DEFAULT_GRID_DIM,
   parameter int ADDRESS_WIDTH = $clog2(GRID_DIM)
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     Start,
   output logic                     Rd_en,
   output logic [ADDRESS_WIDTH-1:0] Rd_addr,
   input  logic [DATA_WIDTH-1:0]    Rd_data,
   output logic [DATA_WIDTH-1:0]    Out_data,
   output logic [ADDRESS_WIDTH-1:0] Out_addr,
   output logic                     Out_valid,
   input  logic                     Out_ready,
   output logic                     Out_last,
   output logic                     Busy,
   output logic                     Done
);
   localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(GRID_DIM - 1);

   grid_rd_state_t           state;
   logic [ADDRESS_WIDTH-1:0] issue_cnt;
   logic [ADDRESS_WIDTH-1:0] pend_addr;
   logic                     rd_pending;
   logic [FIFO_CNT_W-1:0]    fifo_count;
   logic [FIFO_CNT_W-1:0]    in_use;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic                     issue;
   logic                     pop;

   // Every read on the wire or in the capture stage already owns a buffer slot.
   assign in_use    = fifo_count + FIFO_CNT_W'(Rd_en) + FIFO_CNT_W'(rd_pending);
   assign issue     = (state == IDLE && Start)
                   || (state == ISSUE && in_use < FIFO_CNT_W'(FIFO_DEPTH));
   assign Out_valid = !fifo_empty;
   assign Out_last  = Out_valid && (Out_addr == LAST_ADDR);
   assign pop       = Out_valid && Out_ready;

   grid_rd_fifo #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_fifo (
      .Clk       (Clk),
      .Reset     (Reset),
      .push      (rd_pending),
      .push_addr (pend_addr),
      .push_data (Rd_data),
      .pop       (pop),
      .head_addr (Out_addr),
      .head_data (Out_data),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state      <= IDLE;
         issue_cnt  <= '0;
         Rd_en      <= 1'b0;
         Rd_addr    <= '0;
         rd_pending <= 1'b0;
         pend_addr  <= '0;
         Busy       <= 1'b0;
         Done       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let rd_pending/pend_addr take the pre-edge
         // Rd_en/Rd_addr, giving the one-cycle alignment with the RAM's Rd_data.
         Rd_en      <= issue;
         rd_pending <= Rd_en;
         pend_addr  <= Rd_addr;
         Done       <= 1'b0;
         if (issue) begin
            Rd_addr <= issue_cnt;
            if (issue_cnt != LAST_ADDR) begin
               issue_cnt <= issue_cnt + ADDRESS_WIDTH'(1);
            end
         end
         case (state)
            IDLE: begin
               if (Start) begin
                  state <= (issue_cnt == LAST_ADDR) ? DRAIN : ISSUE;
                  Busy  <= 1'b1;
               end
            end
            ISSUE: begin
               if (issue && issue_cnt == LAST_ADDR) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (pop && Out_last) begin
                  state <= DONE;
                  Done  <= 1'b1;
               end
            end
            DONE: begin
               state     <= IDLE;
               Busy      <= 1'b0;
               issue_cnt <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_grid_reader.sv
// Self-checking bench for grid_reader: a 256-cell and a 100-cell instance, each with a
// RAM stand-in and a scoreboard that expects beat k of a sweep to be {k, 3k+1}.
`timescale 1ns/1ps
module tb_grid_reader;
   logic clk;
   logic rst_n;
   logic ready;
   logic start [2];
   int   cyc    = 0;
   int   n_vec  = 0;
   int   n_err  = 0;

   initial begin
      clk = 1'b0;
      #15;
      forever #10 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_vec++;
      if (actual !== expected) begin
         n_err++;
         $display("FAIL %s: actual %0d required %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : env
      localparam int N  = (g == 0) ? 256 : 100;
      localparam int AW = $clog2(N);

      logic          rd_en, out_valid, out_last, busy, done;
      logic [AW-1:0] rd_addr, out_addr;
      logic [15:0]   rd_data, out_data;
      int            beats = 0, rd_cnt = 0, done_cnt = 0;
      int            first_cyc = 0, last_cyc = 0, done_cyc = 0;
      int            k;
      logic          hold_v = 1'b0, hold_l = 1'b0;
      logic [AW-1:0] hold_a = '0;
      logic [15:0]   hold_d = '0;

      grid_reader #(.GRID_DIM(N)) dut (
         .Clk       (clk),
         .Reset     (rst_n),
         .Start     (start[g]),
         .Rd_en     (rd_en),
         .Rd_addr   (rd_addr),
         .Rd_data   (rd_data),
         .Out_data  (out_data),
         .Out_addr  (out_addr),
         .Out_valid (out_valid),
         .Out_ready (ready),
         .Out_last  (out_last),
         .Busy      (busy),
         .Done      (done)
      );

      always @(posedge clk) if (rd_en) rd_data <= 16'(3 * int'(rd_addr) + 1);

      always @(negedge clk) begin
         if (!rst_n) begin
            beats    = 0;
            rd_cnt   = 0;
            done_cnt = 0;
            hold_v   = 1'b0;
         end else begin
            if (hold_v) begin
               check($sformatf("env%0d hold_valid", g), 64'(out_valid), 1);
               check($sformatf("env%0d hold_addr", g), 64'(out_addr), 64'(hold_a));
               check($sformatf("env%0d hold_data", g), 64'(out_data), 64'(hold_d));
               check($sformatf("env%0d hold_last", g), 64'(out_last), 64'(hold_l));
            end
            if (rd_en) begin
               check($sformatf("env%0d rd_order", g), 64'(rd_addr), 64'(rd_cnt % N));
               rd_cnt++;
            end
            if (out_valid && ready) begin
               k = beats % N;
               check($sformatf("env%0d beat_addr", g), 64'(out_addr), 64'(k));
               check($sformatf("env%0d beat_data", g), 64'(out_data), 64'((3 * k + 1) % 65536));
               check($sformatf("env%0d beat_last", g), 64'(out_last), 64'(k == N - 1));
               if (k == 0) first_cyc = cyc;
               if (k == N - 1) last_cyc = cyc;
               beats++;
            end
            if (done) begin
               done_cnt++;
               done_cyc = cyc;
            end
            hold_v = out_valid && !ready;
            hold_a = out_addr;
            hold_d = out_data;
            hold_l = out_last;
         end
      end
   end

   task automatic nedge();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse_start(input bit s0, input bit s1);
      @(posedge clk);
      #2;
      start[0] = s0;
      start[1] = s1;
      @(posedge clk);
      #2;
      start[0] = 1'b0;
      start[1] = 1'b0;
   endtask

   task automatic wait_done0(input int budget, input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         nedge();
         if (env[0].done) seen = 1'b1;
      end
      check({tag, " done_seen"}, 64'(seen), 1);
   endtask

   task automatic check_zero0(input string tag);
      check({tag, " rd_en"},     64'(env[0].rd_en),     0);
      check({tag, " rd_addr"},   64'(env[0].rd_addr),   0);
      check({tag, " out_valid"}, 64'(env[0].out_valid), 0);
      check({tag, " out_data"},  64'(env[0].out_data),  0);
      check({tag, " out_addr"},  64'(env[0].out_addr),  0);
      check({tag, " out_last"},  64'(env[0].out_last),  0);
      check({tag, " busy"},      64'(env[0].busy),      0);
      check({tag, " done"},      64'(env[0].done),      0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: actual still running, required completion");
      $fatal(1);
   end

   initial begin
      int b_beats, b_rd, b_done;
      bit seen;

      ready    = 1'b1;
      start[0] = 1'b0;
      start[1] = 1'b0;
      rst_n    = 1'b1;
      #1 rst_n = 1'b0;
      #4 check_zero0("reset");
      check("reset env1 out_valid", 64'(env[1].out_valid), 0);
      #6 rst_n = 1'b1;

      // Full sweep on both sizes with Out_ready held high.
      pulse_start(1'b1, 1'b1);
      nedge();
      check("lat rd_en", 64'(env[0].rd_en), 1);
      check("lat rd_addr", 64'(env[0].rd_addr), 0);
      check("lat busy", 64'(env[0].busy), 1);
      check("lat valid_c1", 64'(env[0].out_valid), 0);
      check("lat env1 rd_en", 64'(env[1].rd_en), 1);
      nedge();
      check("lat valid_c2", 64'(env[0].out_valid), 0);
      nedge();
      check("lat valid_c3", 64'(env[0].out_valid), 1);
      check("lat addr0", 64'(env[0].out_addr), 0);
      check("lat data0", 64'(env[0].out_data), 1);
      wait_done0(400, "sweep1");
      check("sweep1 beats", 64'(env[0].beats), 256);
      check("sweep1 span", 64'(env[0].last_cyc - env[0].first_cyc), 255);
      check("sweep1 done_after_last", 64'(env[0].done_cyc), 64'(env[0].last_cyc + 1));
      check("sweep1 reads", 64'(env[0].rd_cnt), 256);
      check("small beats", 64'(env[1].beats), 100);
      check("small span", 64'(env[1].last_cyc - env[1].first_cyc), 99);
      check("small done_after_last", 64'(env[1].done_cyc), 64'(env[1].last_cyc + 1));
      check("small reads", 64'(env[1].rd_cnt), 100);
      check("small dones", 64'(env[1].done_cnt), 1);
      nedge();
      check("sweep1 busy_after_done", 64'(env[0].busy), 0);
      check("sweep1 done_pulse_width", 64'(env[0].done), 0);
      check("sweep1 dones", 64'(env[0].done_cnt), 1);

      // Backpressure from the start: exactly four reads, head word held.
      ready  = 1'b0;
      b_rd    = env[0].rd_cnt;
      b_beats = env[0].beats;
      b_done  = env[0].done_cnt;
      pulse_start(1'b1, 1'b0);
      repeat (55) nedge();
      check("bp reads", 64'(env[0].rd_cnt - b_rd), 4);
      check("bp rd_en_idle", 64'(env[0].rd_en), 0);
      check("bp valid", 64'(env[0].out_valid), 1);
      check("bp addr", 64'(env[0].out_addr), 0);
      check("bp data", 64'(env[0].out_data), 1);
      @(posedge clk);
      #2 ready = 1'b1;
      wait_done0(400, "bp");
      check("bp beats", 64'(env[0].beats - b_beats), 256);
      check("bp total_reads", 64'(env[0].rd_cnt - b_rd), 256);
      check("bp dones", 64'(env[0].done_cnt - b_done), 1);

      // Random Out_ready with Start pulsed mid-sweep at beats 10 and 200.
      b_rd    = env[0].rd_cnt;
      b_beats = env[0].beats;
      b_done  = env[0].done_cnt;
      pulse_start(1'b1, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         ready    = 1'($urandom_range(0, 1));
         start[0] = ((env[0].beats - b_beats) == 10) || ((env[0].beats - b_beats) == 200);
         nedge();
         if (env[0].done) seen = 1'b1;
         @(posedge clk);
         #2;
      end
      start[0] = 1'b0;
      ready    = 1'b1;
      check("rand done_seen", 64'(seen), 1);
      repeat (20) nedge();
      check("rand beats", 64'(env[0].beats - b_beats), 256);
      check("rand reads", 64'(env[0].rd_cnt - b_rd), 256);
      check("rand dones", 64'(env[0].done_cnt - b_done), 1);
      check("rand busy_idle", 64'(env[0].busy), 0);

      // Reset at beat 100, then a clean restart and a back-to-back Start after Done.
      pulse_start(1'b1, 1'b0);
      b_beats = env[0].beats;
      for (int i = 0; i < 500 && (env[0].beats - b_beats) < 100; i++) nedge();
      check("midrst reached", 64'(env[0].beats - b_beats >= 100), 1);
      #2 rst_n = 1'b0;
      #1 check_zero0("midrst");
      @(negedge clk);
      #5 rst_n = 1'b1;
      pulse_start(1'b1, 1'b0);
      wait_done0(400, "restart");
      check("restart beats", 64'(env[0].beats), 256);
      check("restart span", 64'(env[0].last_cyc - env[0].first_cyc), 255);
      check("restart dones", 64'(env[0].done_cnt), 1);
      @(posedge clk);
      #2 start[0] = 1'b1;
      @(posedge clk);
      #2 start[0] = 1'b0;
      nedge();
      check("b2b busy", 64'(env[0].busy), 1);
      check("b2b rd_en", 64'(env[0].rd_en), 1);
      wait_done0(400, "b2b");
      check("b2b beats", 64'(env[0].beats), 512);
      check("b2b dones", 64'(env[0].done_cnt), 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/grid_reader.md
Name: grid_reader

Overview:
- Read-side counterpart of the grid initialisation counter, which walks addresses to write lattice memory.
- Sweeps every cell address 0..GRID_DIM-1 of a synchronous lattice RAM (1-cycle read latency) and streams the cell words out over a valid/ready interface.
- Sits between lattice memory and downstream consumers (collision/streaming stage, display/readout path).
- Handles backpressure with an internal credit-controlled 4-entry buffer; one full sweep per Start.

Parameters:
GRID_DIM, 16*16, number of lattice cells swept
ADDRESS_WIDTH, $clog2(GRID_DIM), width of cell address
DATA_WIDTH, 16, width of one cell word

Ports:
Clk  in  1  system clock, 50 MHz, rising edge
Reset  in  1  asynchronous, active-low reset (0 = reset)
Start  in  1  begin a sweep; sampled only in IDLE
Rd_en  out  1  memory read strobe, registered
Rd_addr  out  ADDRESS_WIDTH  memory read address, registered
Rd_data  in  DATA_WIDTH  memory data, valid the cycle after Rd_en
Out_data  out  DATA_WIDTH  cell word
Out_addr  out  ADDRESS_WIDTH  address of Out_data
Out_valid  out  1  beat available
Out_ready  in  1  consumer accepts beat
Out_last  out  1  beat is address GRID_DIM-1
Busy  out  1  high from the cycle after Start is accepted until Done
Done  out  1  one-cycle pulse after last beat accepted

Behaviour:
- Reset (async assert, sync deassert handled externally): all outputs 0, FSM IDLE, FIFO empty, issue counter 0, outstanding reads discarded.
- FSM states:
  - IDLE: Start=1 -> ISSUE.
  - ISSUE: issue reads. After address GRID_DIM-1 is issued -> DRAIN.
  - DRAIN: FIFO empties. Handshake with Out_last -> DONE.
  - DONE: Done=1 for one cycle -> IDLE.
  - Busy=1 in ISSUE, DRAIN and DONE.
- Start is ignored in every state except IDLE.
- Issue rule: a read is issued when state is ISSUE and (FIFO occupancy + reads in flight) < 4.
  - Rd_en=1 and Rd_addr=issue counter are presented the next cycle; the issue counter then increments.
  - Rd_en=0 on all other cycles.
  - Rd_addr holds its last value when Rd_en=0.
- Capture: Rd_data from a read issued in cycle t is written into the FIFO at the end of cycle t+1, together with its address.
- Latency: Start sampled at edge E0 -> Rd_en high after E0 -> Rd_data present after E1 -> Out_valid high after E2. First beat is visible 3 cycles after the Start edge.
- Throughput: one beat per cycle while Out_ready=1. GRID_DIM beats appear in GRID_DIM consecutive cycles.
- Handshake:
  - A beat transfers when Out_valid & Out_ready.
  - Out_data, Out_addr and Out_last are stable while Out_valid=1 and Out_ready=0.
  - Out_valid never drops without a transfer.
  - Out_ready may be high while Out_valid=0 (no effect).
- Ordering: beats are strictly in address order 0..GRID_DIM-1, with no duplicates and no gaps.
- Boundary conditions:
  - Issue counter stops at GRID_DIM-1 (no wrap).
  - Non-power-of-two GRID_DIM is supported.
  - Simultaneous FIFO push and pop in the same cycle is legal at any occupancy, including full.
  - Credits guarantee the FIFO never overflows; overflow is an assertion failure.
- Reset mid-sweep: immediate return to the reset values above. The next Start restarts from address 0.
- Done and the following IDLE cycle: Start may be asserted in the cycle after Done and is accepted.

Decomposition:
- Package lbm_grid_pkg:
  - GRID_DIM default and ADDRESS_WIDTH localparam.
  - Cell word type logic [DATA_WIDTH-1:0].
  - Enum grid_rd_state_t {IDLE, ISSUE, DRAIN, DONE}.
- Sub-module grid_rd_fifo: 4-entry synchronous FIFO of {addr, data}.
  - Ports: push, pop, count, full, empty; same Clk/Reset convention.
  - Occupancy output feeds the credit check.
- Top level: FSM, issue counter, in-flight flag, Out_last = head address == GRID_DIM-1.

Test Plan:
- Memory model Rd_data = 3*addr+1 (mod 2^16), 1-cycle latency. Reset low 10 ns, Start pulse, Out_ready=1 -> Out_valid rises 3 cycles after Start edge. Out_addr 0..255 on 256 consecutive cycles with Out_data=3*addr+1. Out_last only at 255. Done pulse one cycle after beat 255. Busy low the cycle after Done.
- Out_ready held 0 after Start -> exactly 4 Rd_en pulses (addr 0..3), then Rd_en=0. Out_valid=1 with addr 0 stable for 50 cycles. Release -> sweep completes with no loss or duplication.
- Random Out_ready (50%) across a full sweep -> scoreboard sees 256 in-order beats. Data stable whenever valid & !ready. FIFO never overflows.
- Start pulsed at beats 10 and 200 during a sweep -> ignored. Exactly one sweep and one Done.
- Reset asserted at beat 100 -> all outputs 0 asynchronously. Subsequent Start -> first beat addr 0, full 256-beat sweep.
- GRID_DIM=100 (ADDRESS_WIDTH=7) -> 100 beats, Out_last at addr 99, no read of addr ≥100.
